// File: rtl/vga_sync_gen.sv
// vga_sync_gen
// Generates VGA raster timing from a fast system clock. A clock divider
// produces a one-clock pixel enable (p_tick). On each p_tick the column and
// row counters x/y advance, and hsync, vsync and video_on are registered from
// the next-state counter values, so they always line up with the registered
// x and y (no pipeline offset).
//
// Optional feature: define VGA_FRAME_TICK_EN to build frame_tick, a
// one-clock pulse in the clock where the counters become (0, V_DISPLAY),
// which is the first pixel of vertical blanking. Without the macro,
// frame_tick is tied to 0.
//
// Ports
//   clk        in   system clock
//   reset_n    in   synchronous, active-low reset
//   p_tick     out  one-clock pulse per pixel period
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   video_on   out  high while (x,y) is inside the visible area
//   x          out  current pixel column, 0..H_TOTAL-1
//   y          out  current line, 0..V_TOTAL-1
//   frame_tick out  start-of-vertical-blank pulse (VGA_FRAME_TICK_EN only)
module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       p_tick,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // A one-clock divider still needs a 1-bit counter; it simply never leaves 0.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             div_wrap;
  logic [9:0]       x_next;
  logic [9:0]       y_next;

  assign div_wrap = (div_cnt == DIV_MAX);

  // Next-state counters: they only move on the divider wrap, so every
  // registered output derived from them changes together with x/y.
  always_comb begin
    x_next = x;
    y_next = y;
    if (div_wrap) begin
      if (x == H_MAX) begin
        x_next = 10'd0;
        if (y == V_MAX) y_next = 10'd0;
        else            y_next = y + 10'd1;
      end else begin
        x_next = x + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt  <= '0;
      p_tick   <= 1'b0;
      x        <= 10'd0;
      y        <= 10'd0;
      hsync    <= 1'b1;
      vsync    <= 1'b1;
      video_on <= 1'b0;
    end else begin
      div_cnt  <= div_wrap ? '0 : div_cnt + 1'b1;
      p_tick   <= div_wrap;
      x        <= x_next;
      y        <= y_next;
      hsync    <= !((x_next >= HS_START) && (x_next <= HS_END));
      vsync    <= !((y_next >= VS_START) && (y_next <= VS_END));
      video_on <= (x_next < H_VIS) && (y_next < V_VIS);
    end
  end

`ifdef VGA_FRAME_TICK_EN
  // Fires only on the wrap edge, so it is one clock wide even though the
  // counters sit at (0, V_DISPLAY) for a whole pixel period.
  always_ff @(posedge clk) begin
    if (!reset_n) frame_tick <= 1'b0;
    else          frame_tick <= div_wrap && (x_next == 10'd0) && (y_next == V_VIS);
  end
`else
  assign frame_tick = 1'b0;
`endif

endmodule
